mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory stage of the RISC-V pipeline and consumer of the execute-stage result bundle (`ex_*` registers). Non-memory results pass through to writeback in one cycle. Loads and stores run a request/acknowledge transaction on the data-memory port, holding the pipeline through `mem_stall_w` until the access completes. Load data is aligned and sign/zero-extended, and store byte lanes are generated here.

## Interface
No parameters; sizes come from `defines.sv` (`SIZE_BYTE`, `SIZE_HALF`, `SIZE_WORD`).
- `clk_i` input 1: clock; all state updates on rising edge.
- `reset_i` input 1: synchronous, active-high reset.
- `ex_rd_index_r` input 5: destination register from execute.
- `ex_alu_res_r` input 32: ALU result; byte address when accessing memory.
- `ex_mem_data_r` input 32: store data (rb value).
- `ex_mem_rd_r` input 1: load request.
- `ex_mem_wr_r` input 1: store request.
- `ex_mem_signed_r` input 1: sign-extend load data.
- `ex_mem_size_r` input 2: access size.
- `dmem_req_o` output 1: bus request, registered.
- `dmem_we_o` output 1: 1 = write.
- `dmem_addr_o` output 32: word-aligned address (`[1:0]` = 0).
- `dmem_wdata_o` output 32: lane-replicated store data.
- `dmem_wstrb_o` output 4: byte enables; 0 for reads.
- `dmem_rdata_i` input 32: read word, valid with ack.
- `dmem_ack_i` input 1: one-cycle completion pulse.
- `mem_rd_index_r` output 5: writeback destination; 0 = no write.
- `mem_rd_value_r` output 32: writeback value.
- `mem_stall_w` output 1: combinational; execute must hold its outputs while 1.
- `mem_misalign_o` output 1: misalignment pulse (see Configuration).
- `mem_misalign_addr_o` output 32: faulting address.

## Operation
- FSM states are IDLE and WAIT.
- **IDLE, no access** (`ex_mem_rd_r` and `ex_mem_wr_r` both 0): each edge, `mem_rd_index_r <= ex_rd_index_r` and `mem_rd_value_r <= ex_alu_res_r`. `mem_stall_w` = 0.
- **IDLE, access present:**
  - `mem_stall_w` = 1.
  - On the edge, register `dmem_req_o` = 1, `dmem_we_o` = `ex_mem_wr_r`, `dmem_addr_o` = `{addr[31:2],2'b00}`, strobes and wdata. Capture offset, size, signed and rd index.
  - `mem_rd_index_r` <= 0 (bubble). Go to WAIT.
- **Both rd and wr set:** treated as a store.
- **Store lanes:**
  - byte: wdata = `{4{d[7:0]}}`, wstrb = `4'b0001 << off`.
  - half: wdata = `{2{d[15:0]}}`, wstrb = `4'b0011 << off`.
  - word: wdata = d, wstrb = `4'b1111`.
- **WAIT:**
  - All `dmem_*` outputs are held stable. `mem_stall_w` = `!dmem_ack_i`.
  - On ack: `dmem_req_o` <= 0, `dmem_we_o` <= 0, `dmem_wstrb_o` <= 0. Go to IDLE.
  - Load on ack: `mem_rd_index_r` <= captured index, `mem_rd_value_r` <= extracted value. Byte = `rdata[8*off+:8]`, half = `rdata[8*off+:16]`, extended by the signed flag.
  - Store on ack: `mem_rd_index_r` <= 0, `mem_rd_value_r` <= 0.
- **Misalignment:** half with `off[0]` = 1, or word with `off` ≠ 0 (handling per Configuration).
- **Reset values:** state IDLE; every output register is 0 (`dmem_req_o`, `dmem_we_o`, `dmem_addr_o`, `dmem_wdata_o`, `dmem_wstrb_o`, `mem_rd_index_r`, `mem_rd_value_r`, `mem_misalign_o`, `mem_misalign_addr_o`).

## Timing
- **Non-memory op:** 1-cycle latency, no stall.
- **Memory op:** the request is visible the cycle after the access appears; earliest ack is that same cycle.
  - Minimum occupancy is 2 cycles with 2 stall-cycles-minus-ack (stall in IDLE cycle; stall drops in the ack cycle).
  - Writeback is valid the cycle after ack.
- **Ack in IDLE:** ignored.
- **Back-to-back accesses:** the next access is seen in IDLE the cycle after ack. No request gap is required beyond one cycle with `dmem_req_o` = 0.
- **Reset mid-WAIT:** `dmem_req_o` drops at that edge. The outstanding transaction is abandoned and a later ack is ignored in IDLE.

## Configuration
- **`MEM_MISALIGN_TRAP_EN` defined:**
  - A misaligned access in IDLE issues no bus request and causes no stall.
  - `mem_misalign_o` pulses 1 for one cycle and `mem_misalign_addr_o` <= `ex_alu_res_r`.
  - `mem_rd_index_r` <= 0. The state stays IDLE.
- **Undefined:**
  - Misaligned accesses proceed with the offset forced down: half uses `off & 2'b10`, word uses 0.
  - `mem_misalign_o` and `mem_misalign_addr_o` are tied to 0.

## Test plan
- ADD result `0x1234` to x5, no memory op -> next cycle `mem_rd_index_r` = 5, value `0x1234`, `mem_stall_w` never 1.
- Signed byte load from `0x1003`, ack after 3 WAIT cycles with rdata `0x80FF_0000` -> `addr_o` = `0x1000`, stall for 4 cycles, value `0xFFFFFF80`.
- Half store of `0xABCD` to `0x2002` -> wdata `0xABCDABCD`, wstrb `4'b1100`, we = 1, `mem_rd_index_r` = 0 after ack.
- Unsigned half load from `0x3002`, rdata `0x8001_0000`, ack in first WAIT cycle -> value `0x00008001`; back-to-back second load issues the next request two cycles later.
- Word load to `0x4001`: with `MEM_MISALIGN_TRAP_EN`, no request, `mem_misalign_o` = 1 for one cycle, addr `0x4001`; without it, a request to `0x4000` returns the full word.
- Reset asserted in WAIT, then a late ack -> `dmem_req_o` = 0 after the reset edge, no writeback, state IDLE.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory stage: forwards ALU results, runs load/store req/ack transactions, aligns load data.
// Optional MEM_MISALIGN_TRAP_EN: misaligned accesses raise mem_misalign_o instead of reaching the bus.

`ifndef SIZE_BYTE
`define SIZE_BYTE 2'd0
`endif
`ifndef SIZE_HALF
`define SIZE_HALF 2'd1
`endif
`ifndef SIZE_WORD
`define SIZE_WORD 2'd2
`endif

module mem_access_stage (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [4:0]  ex_rd_index_r,
    input  logic [31:0] ex_alu_res_r,
    input  logic [31:0] ex_mem_data_r,
    input  logic        ex_mem_rd_r,
    input  logic        ex_mem_wr_r,
    input  logic        ex_mem_signed_r,
    input  logic [1:0]  ex_mem_size_r,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_wstrb_o,
    input  logic [31:0] dmem_rdata_i,
    input  logic        dmem_ack_i,
    output logic [4:0]  mem_rd_index_r,
    output logic [31:0] mem_rd_value_r,
    output logic        mem_stall_w,
    output logic        mem_misalign_o,
    output logic [31:0] mem_misalign_addr_o
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state_reg, state_next;
    logic [1:0]  off_reg, off_next;
    logic [1:0]  size_reg, size_next;
    logic        signed_reg, signed_next;
    logic [4:0]  cap_index_reg, cap_index_next;
    logic        req_next, we_next;
    logic [31:0] addr_next, wdata_next;
    logic [3:0]  wstrb_next;
    logic [4:0]  rd_index_next;
    logic [31:0] rd_value_next;

    logic        access;
    logic [1:0]  off;
    logic [1:0]  eff_off;
    logic        trap;
    logic [31:0] rdata_shifted;
    logic [31:0] load_value;

    assign access = ex_mem_rd_r | ex_mem_wr_r;
    assign off    = ex_alu_res_r[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign;
    logic        misalign_reg;
    logic [31:0] misalign_addr_reg;

    assign misalign = (ex_mem_size_r == `SIZE_HALF) ? off[0] :
                      (ex_mem_size_r == `SIZE_BYTE) ? 1'b0 : (off != 2'b00);
    assign trap     = access & misalign;
    assign eff_off  = off;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            misalign_reg      <= 1'b0;
            misalign_addr_reg <= 32'd0;
        end else begin
            misalign_reg <= (state_reg == IDLE) && trap;
            if ((state_reg == IDLE) && trap)
                misalign_addr_reg <= ex_alu_res_r;
        end
    end

    assign mem_misalign_o      = misalign_reg;
    assign mem_misalign_addr_o = misalign_addr_reg;
`else
    // Misaligned accesses are silently aligned down to the natural boundary.
    assign trap    = 1'b0;
    assign eff_off = (ex_mem_size_r == `SIZE_BYTE) ? off :
                     (ex_mem_size_r == `SIZE_HALF) ? (off & 2'b10) : 2'b00;
    assign mem_misalign_o      = 1'b0;
    assign mem_misalign_addr_o = 32'd0;
`endif

    assign mem_stall_w = (state_reg == IDLE) ? (access & ~trap) : ~dmem_ack_i;

    assign rdata_shifted = dmem_rdata_i >> {off_reg, 3'b000};
    always_comb begin
        load_value = dmem_rdata_i;
        if (size_reg == `SIZE_BYTE)
            load_value = {{24{signed_reg & rdata_shifted[7]}}, rdata_shifted[7:0]};
        else if (size_reg == `SIZE_HALF)
            load_value = {{16{signed_reg & rdata_shifted[15]}}, rdata_shifted[15:0]};
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg      <= IDLE;
            off_reg        <= 2'd0;
            size_reg       <= 2'd0;
            signed_reg     <= 1'b0;
            cap_index_reg  <= 5'd0;
            dmem_req_o     <= 1'b0;
            dmem_we_o      <= 1'b0;
            dmem_addr_o    <= 32'd0;
            dmem_wdata_o   <= 32'd0;
            dmem_wstrb_o   <= 4'd0;
            mem_rd_index_r <= 5'd0;
            mem_rd_value_r <= 32'd0;
        end else begin
            state_reg      <= state_next;
            off_reg        <= off_next;
            size_reg       <= size_next;
            signed_reg     <= signed_next;
            cap_index_reg  <= cap_index_next;
            dmem_req_o     <= req_next;
            dmem_we_o      <= we_next;
            dmem_addr_o    <= addr_next;
            dmem_wdata_o   <= wdata_next;
            dmem_wstrb_o   <= wstrb_next;
            mem_rd_index_r <= rd_index_next;
            mem_rd_value_r <= rd_value_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        off_next       = off_reg;
        size_next      = size_reg;
        signed_next    = signed_reg;
        cap_index_next = cap_index_reg;
        req_next       = dmem_req_o;
        we_next        = dmem_we_o;
        addr_next      = dmem_addr_o;
        wdata_next     = dmem_wdata_o;
        wstrb_next     = dmem_wstrb_o;
        rd_index_next  = mem_rd_index_r;
        rd_value_next  = mem_rd_value_r;

        case (state_reg)
            IDLE: begin
                if (!access) begin
                    rd_index_next = ex_rd_index_r;
                    rd_value_next = ex_alu_res_r;
                end else if (trap) begin
                    rd_index_next = 5'd0;
                end else begin
                    req_next       = 1'b1;
                    we_next        = ex_mem_wr_r;
                    addr_next      = {ex_alu_res_r[31:2], 2'b00};
                    off_next       = eff_off;
                    size_next      = ex_mem_size_r;
                    signed_next    = ex_mem_signed_r;
                    cap_index_next = ex_rd_index_r;
                    rd_index_next  = 5'd0;
                    state_next     = WAIT;
                    if (ex_mem_size_r == `SIZE_BYTE) begin
                        wdata_next = {4{ex_mem_data_r[7:0]}};
                        wstrb_next = 4'b0001 << eff_off;
                    end else if (ex_mem_size_r == `SIZE_HALF) begin
                        wdata_next = {2{ex_mem_data_r[15:0]}};
                        wstrb_next = 4'b0011 << eff_off;
                    end else begin
                        wdata_next = ex_mem_data_r;
                        wstrb_next = 4'b1111;
                    end
                    // Reads carry no byte enables; wdata is don't-care for them.
                    if (!ex_mem_wr_r)
                        wstrb_next = 4'b0000;
                end
            end
            WAIT: begin
                if (dmem_ack_i) begin
                    req_next   = 1'b0;
                    we_next    = 1'b0;
                    wstrb_next = 4'b0000;
                    state_next = IDLE;
                    if (dmem_we_o) begin
                        rd_index_next = 5'd0;
                        rd_value_next = 32'd0;
                    end else begin
                        rd_index_next = cap_index_reg;
                        rd_value_next = load_value;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage; covers both builds of MEM_MISALIGN_TRAP_EN.
module tb_mem_access_stage;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [4:0]  ex_rd_index_r;
    logic [31:0] ex_alu_res_r;
    logic [31:0] ex_mem_data_r;
    logic        ex_mem_rd_r;
    logic        ex_mem_wr_r;
    logic        ex_mem_signed_r;
    logic [1:0]  ex_mem_size_r;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [3:0]  dmem_wstrb_o;
    logic [31:0] dmem_rdata_i;
    logic        dmem_ack_i;
    logic [4:0]  mem_rd_index_r;
    logic [31:0] mem_rd_value_r;
    logic        mem_stall_w;
    logic        mem_misalign_o;
    logic [31:0] mem_misalign_addr_o;

    int checks = 0;
    int passed = 0;

    mem_access_stage dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .ex_rd_index_r(ex_rd_index_r), .ex_alu_res_r(ex_alu_res_r),
        .ex_mem_data_r(ex_mem_data_r), .ex_mem_rd_r(ex_mem_rd_r),
        .ex_mem_wr_r(ex_mem_wr_r), .ex_mem_signed_r(ex_mem_signed_r),
        .ex_mem_size_r(ex_mem_size_r),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_wstrb_o(dmem_wstrb_o), .dmem_rdata_i(dmem_rdata_i),
        .dmem_ack_i(dmem_ack_i),
        .mem_rd_index_r(mem_rd_index_r), .mem_rd_value_r(mem_rd_value_r),
        .mem_stall_w(mem_stall_w),
        .mem_misalign_o(mem_misalign_o), .mem_misalign_addr_o(mem_misalign_addr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
            $display("check %-16s obs=%h exp=%h ok", tag, obs, exp);
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic ex_clear();
        ex_rd_index_r   = 5'd0;
        ex_alu_res_r    = 32'd0;
        ex_mem_data_r   = 32'd0;
        ex_mem_rd_r     = 1'b0;
        ex_mem_wr_r     = 1'b0;
        ex_mem_signed_r = 1'b0;
        ex_mem_size_r   = 2'd0;
    endtask

    initial begin
        reset_i      = 1'b1;
        dmem_rdata_i = 32'd0;
        dmem_ack_i   = 1'b0;
        ex_clear();
        tick();
        tick();
        chk("rst_req", {31'd0, dmem_req_o}, 32'd0);
        chk("rst_we", {31'd0, dmem_we_o}, 32'd0);
        chk("rst_addr", dmem_addr_o, 32'd0);
        chk("rst_wdata", dmem_wdata_o, 32'd0);
        chk("rst_wstrb", {28'd0, dmem_wstrb_o}, 32'd0);
        chk("rst_rd_index", {27'd0, mem_rd_index_r}, 32'd0);
        chk("rst_rd_value", mem_rd_value_r, 32'd0);
        chk("rst_misalign", {31'd0, mem_misalign_o}, 32'd0);
        chk("rst_mis_addr", mem_misalign_addr_o, 32'd0);
        reset_i = 1'b0;

        // ALU pass-through
        ex_rd_index_r = 5'd5; ex_alu_res_r = 32'h1234;
        #1 chk("alu_stall", {31'd0, mem_stall_w}, 32'd0);
        tick();
        chk("alu_index", {27'd0, mem_rd_index_r}, 32'd5);
        chk("alu_value", mem_rd_value_r, 32'h1234);

        // Signed byte load from 0x1003, ack in the 4th WAIT cycle
        ex_rd_index_r = 5'd7; ex_alu_res_r = 32'h1003; ex_mem_rd_r = 1'b1;
        ex_mem_signed_r = 1'b1; ex_mem_size_r = 2'd0;
        #1 chk("lb_stall_idle", {31'd0, mem_stall_w}, 32'd1);
        tick();
        chk("lb_req", {31'd0, dmem_req_o}, 32'd1);
        chk("lb_we", {31'd0, dmem_we_o}, 32'd0);
        chk("lb_addr", dmem_addr_o, 32'h1000);
        chk("lb_wstrb", {28'd0, dmem_wstrb_o}, 32'd0);
        chk("lb_bubble", {27'd0, mem_rd_index_r}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("lb_stall_wait", {31'd0, mem_stall_w}, 32'd1);
            tick();
        end
        chk("lb_req_held", {31'd0, dmem_req_o}, 32'd1);
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'h80FF_0000;
        #1 chk("lb_stall_ack", {31'd0, mem_stall_w}, 32'd0);
        ex_clear();
        tick();
        dmem_ack_i = 1'b0;
        chk("lb_req_drop", {31'd0, dmem_req_o}, 32'd0);
        chk("lb_index", {27'd0, mem_rd_index_r}, 32'd7);
        chk("lb_value", mem_rd_value_r, 32'hFFFF_FF80);

        // Half store of 0xABCD to 0x2002, ack in the first WAIT cycle
        ex_rd_index_r = 5'd9; ex_alu_res_r = 32'h2002; ex_mem_data_r = 32'h1234_ABCD;
        ex_mem_wr_r = 1'b1; ex_mem_size_r = 2'd1;
        tick();
        chk("sh_req", {31'd0, dmem_req_o}, 32'd1);
        chk("sh_we", {31'd0, dmem_we_o}, 32'd1);
        chk("sh_addr", dmem_addr_o, 32'h2000);
        chk("sh_wdata", dmem_wdata_o, 32'hABCD_ABCD);
        chk("sh_wstrb", {28'd0, dmem_wstrb_o}, 32'hC);
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'hDEAD_BEEF;
        ex_clear();
        tick();
        dmem_ack_i = 1'b0;
        chk("sh_index", {27'd0, mem_rd_index_r}, 32'd0);
        chk("sh_value", mem_rd_value_r, 32'd0);
        chk("sh_wstrb_clr", {28'd0, dmem_wstrb_o}, 32'd0);
        chk("sh_we_clr", {31'd0, dmem_we_o}, 32'd0);

        // Unsigned half load from 0x3002 then back-to-back byte load
        ex_rd_index_r = 5'd3; ex_alu_res_r = 32'h3002; ex_mem_rd_r = 1'b1; ex_mem_size_r = 2'd1;
        tick();
        chk("lh_req", {31'd0, dmem_req_o}, 32'd1);
        chk("lh_addr", dmem_addr_o, 32'h3000);
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'h8001_0000;
        tick();
        dmem_ack_i = 1'b0;
        chk("lh_req_gap", {31'd0, dmem_req_o}, 32'd0);
        chk("lh_index", {27'd0, mem_rd_index_r}, 32'd3);
        chk("lh_value", mem_rd_value_r, 32'h0000_8001);
        ex_rd_index_r = 5'd4; ex_alu_res_r = 32'h3004; ex_mem_signed_r = 1'b1; ex_mem_size_r = 2'd0;
        #1 chk("lb2_stall", {31'd0, mem_stall_w}, 32'd1);
        tick();
        chk("lb2_req", {31'd0, dmem_req_o}, 32'd1);
        chk("lb2_addr", dmem_addr_o, 32'h3004);
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'hFFFF_FF7F;
        ex_clear();
        tick();
        dmem_ack_i = 1'b0;
        chk("lb2_index", {27'd0, mem_rd_index_r}, 32'd4);
        chk("lb2_value", mem_rd_value_r, 32'h0000_007F);

        // Misaligned word load from 0x4001
        ex_rd_index_r = 5'd6; ex_alu_res_r = 32'h4001; ex_mem_rd_r = 1'b1; ex_mem_size_r = 2'd2;
`ifdef MEM_MISALIGN_TRAP_EN
        #1 chk("mis_stall", {31'd0, mem_stall_w}, 32'd0);
        tick();
        chk("mis_pulse", {31'd0, mem_misalign_o}, 32'd1);
        chk("mis_addr", mem_misalign_addr_o, 32'h4001);
        chk("mis_noreq", {31'd0, dmem_req_o}, 32'd0);
        chk("mis_index", {27'd0, mem_rd_index_r}, 32'd0);
        ex_clear();
        tick();
        chk("mis_pulse_end", {31'd0, mem_misalign_o}, 32'd0);
`else
        #1 chk("mis_stall", {31'd0, mem_stall_w}, 32'd1);
        tick();
        chk("mis_req", {31'd0, dmem_req_o}, 32'd1);
        chk("mis_addr", dmem_addr_o, 32'h4000);
        chk("mis_flag", {31'd0, mem_misalign_o}, 32'd0);
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'hCAFE_F00D;
        ex_clear();
        tick();
        dmem_ack_i = 1'b0;
        chk("mis_index", {27'd0, mem_rd_index_r}, 32'd6);
        chk("mis_value", mem_rd_value_r, 32'hCAFE_F00D);
`endif

        // Word access with rd and wr both set acts as store; reset while in WAIT
        ex_rd_index_r = 5'd10; ex_alu_res_r = 32'h5000; ex_mem_data_r = 32'h1122_3344;
        ex_mem_rd_r = 1'b1; ex_mem_wr_r = 1'b1; ex_mem_size_r = 2'd2;
        tick();
        chk("sw_we", {31'd0, dmem_we_o}, 32'd1);
        chk("sw_wstrb", {28'd0, dmem_wstrb_o}, 32'hF);
        chk("sw_wdata", dmem_wdata_o, 32'h1122_3344);
        tick();
        chk("sw_stall_wait", {31'd0, mem_stall_w}, 32'd1);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        ex_clear();
        chk("rstw_req", {31'd0, dmem_req_o}, 32'd0);
        chk("rstw_wstrb", {28'd0, dmem_wstrb_o}, 32'd0);
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'hBAD0_BAD0;
        #1 chk("rstw_stall", {31'd0, mem_stall_w}, 32'd0);
        tick();
        dmem_ack_i = 1'b0;
        chk("late_ack_index", {27'd0, mem_rd_index_r}, 32'd0);
        chk("late_ack_req", {31'd0, dmem_req_o}, 32'd0);
        ex_rd_index_r = 5'd8; ex_alu_res_r = 32'h55;
        tick();
        chk("post_idle_index", {27'd0, mem_rd_index_r}, 32'd8);
        chk("post_idle_value", mem_rd_value_r, 32'h55);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
